// File: rtl/text_pkg.sv
// Shared constants and types for the VGA text line buffer controller.
package text_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_FF    = 8'h0C;

    // Ascending range so that element 0 is the leftmost character of the string.
    localparam logic [0:15][7:0] DEFAULT_TEXT = "Driving IT 2025 ";

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        CLEAR
    } state_t;

endpackage

// File: rtl/text_cmd_fifo.sv
// Small synchronous FIFO that queues host characters until they can be committed.
module text_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Character line buffer for the VGA text renderer: queued host writes land only
// during vblank, a marquee offset advances per frame, and lookups take one cycle.
module text_buffer_ctrl
    import text_pkg::*;
#(
    parameter int TEXT_LENGTH = 16,
    parameter int IDX_W       = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int SCROLL_DIV  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic             vblank,
    input  logic             frame_start,
    input  logic             scroll_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic [7:0]       rd_char,
    output logic [IDX_W-1:0] scroll_offset,
    output logic [IDX_W-1:0] cursor,
    output logic             busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                          state;
    state_t                          state_next;
    logic [0:TEXT_LENGTH-1][7:0]     buffer;
    logic [IDX_W-1:0]                clear_cnt;
    logic [IDX_W-1:0]                cursor_next;
    logic [IDX_W-1:0]                rd_addr;
    logic [IDX_W-1:0]                buf_waddr;
    logic [7:0]                      buf_wdata;
    logic                            buf_we;
    logic [7:0]                      frame_cnt;
    logic                            push;
    logic                            pop;
    logic [7:0]                      fifo_dout;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic [CNT_W-1:0]                fifo_count;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready;
    assign rd_addr  = rd_index + scroll_offset;

    text_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wr_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // COMMIT leaves as soon as the pop it performs drains the queue, so busy drops promptly.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (vblank && !fifo_empty) state_next = COMMIT;
            end
            COMMIT: begin
                if (!vblank || fifo_empty)                       state_next = IDLE;
                else if (fifo_dout == CHAR_FF)                   state_next = CLEAR;
                else if (fifo_count == CNT_W'(1) && !push)       state_next = IDLE;
            end
            CLEAR: begin
                if (clear_cnt == IDX_W'(TEXT_LENGTH - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        pop         = 1'b0;
        buf_we      = 1'b0;
        buf_waddr   = '0;
        buf_wdata   = CHAR_SPACE;
        cursor_next = cursor;
        case (state)
            COMMIT: begin
                if (vblank && !fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_dout == CHAR_CR) begin
                        cursor_next = '0;
                    end else if (fifo_dout != CHAR_FF) begin
                        buf_we      = 1'b1;
                        buf_waddr   = cursor;
                        buf_wdata   = fifo_dout;
                        cursor_next = cursor + 1'b1;
                    end
                end
            end
            CLEAR: begin
                buf_we    = 1'b1;
                buf_waddr = clear_cnt;
                if (clear_cnt == IDX_W'(TEXT_LENGTH - 1)) cursor_next = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer    <= DEFAULT_TEXT;
            cursor    <= '0;
            clear_cnt <= '0;
            rd_char   <= CHAR_SPACE;
        end else begin
            if (buf_we) buffer[buf_waddr] <= buf_wdata;
            cursor    <= cursor_next;
            clear_cnt <= (state == CLEAR) ? clear_cnt + 1'b1 : '0;
            rd_char   <= buffer[rd_addr];
        end
    end

    // The frame counter ticks 0..SCROLL_DIV-1; the wrap is what advances the marquee.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt     <= '0;
            scroll_offset <= '0;
        end else if (frame_start && scroll_en) begin
            if (frame_cnt == 8'(SCROLL_DIV - 1)) begin
                frame_cnt     <= '0;
                scroll_offset <= scroll_offset + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl with a cycle-level reference model of the buffer behaviour.
module tb_text_buffer_ctrl;

    localparam int TL    = 16;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       vblank = 1'b0;
    logic       frame_start = 1'b0;
    logic       scroll_en = 1'b0;
    logic [3:0] rd_index = 4'd0;
    logic       wr_ready;
    logic [7:0] rd_char;
    logic [3:0] scroll_offset;
    logic [3:0] cursor;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_buffer_ctrl #(
        .TEXT_LENGTH (TL),
        .IDX_W       (4),
        .FIFO_DEPTH  (DEPTH),
        .SCROLL_DIV  (DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .vblank        (vblank),
        .frame_start   (frame_start),
        .scroll_en     (scroll_en),
        .rd_index      (rd_index),
        .rd_char       (rd_char),
        .scroll_offset (scroll_offset),
        .cursor        (cursor),
        .busy          (busy)
    );

    // "Driving IT 2025 " spelled out byte by byte.
    logic [7:0] default_text [TL] = '{8'h44, 8'h72, 8'h69, 8'h76, 8'h69, 8'h6E, 8'h67, 8'h20,
                                      8'h49, 8'h54, 8'h20, 8'h32, 8'h30, 8'h32, 8'h35, 8'h20};

    // Reference model state: buffer contents, pending queue and what the outputs should read.
    logic [7:0] m_buf [TL];
    logic [7:0] m_q [$];
    int         m_cursor;
    int         m_offset;
    int         m_frames;
    bit         m_committing;
    int         m_clear_left;
    logic [7:0] m_rd_char;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TL; i++) m_buf[i] = default_text[i];
        m_q.delete();
        m_cursor     = 0;
        m_offset     = 0;
        m_frames     = 0;
        m_committing = 1'b0;
        m_clear_left = 0;
        m_rd_char    = 8'h20;
    endtask

    task automatic model_step();
        logic [7:0] c;
        logic [7:0] rd_next;
        bit         push_now;
        rd_next  = m_buf[(int'(rd_index) + m_offset) % TL];
        push_now = wr_valid && (m_q.size() < DEPTH);
        if (m_clear_left > 0) begin
            m_buf[TL - m_clear_left] = 8'h20;
            m_clear_left--;
            if (m_clear_left == 0) m_cursor = 0;
        end else if (m_committing) begin
            if (!vblank) begin
                m_committing = 1'b0;
            end else begin
                c = m_q.pop_front();
                if (c == 8'h0D) begin
                    m_cursor = 0;
                end else if (c == 8'h0C) begin
                    m_committing = 1'b0;
                    m_clear_left = TL;
                end else begin
                    m_buf[m_cursor] = c;
                    m_cursor = (m_cursor + 1) % TL;
                end
            end
        end else if (vblank && m_q.size() > 0) begin
            m_committing = 1'b1;
        end
        if (push_now) m_q.push_back(wr_data);
        if (m_committing && m_q.size() == 0) m_committing = 1'b0;
        if (frame_start && scroll_en) begin
            m_frames++;
            if (m_frames == DIV) begin
                m_frames = 0;
                m_offset = (m_offset + 1) % TL;
            end
        end
        m_rd_char = rd_next;
    endtask

    // Every cycle: advance the model on the edge, then compare just after it.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        checkOutput("cyc_rd_char",  rd_char,       m_rd_char);
        checkOutput("cyc_cursor",   cursor,        m_cursor);
        checkOutput("cyc_offset",   scroll_offset, m_offset);
        checkOutput("cyc_wr_ready", wr_ready,      (m_q.size() < DEPTH) ? 1 : 0);
        checkOutput("cyc_busy",     busy,          (m_committing || m_clear_left > 0) ? 1 : 0);
    end

    task automatic applyStimulus(input logic [7:0] d);
        int waited = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("push_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic read_cell(input int idx, output logic [7:0] val);
        rd_index = 4'(idx);
        @(posedge clk);
        #1 val = rd_char;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int waited = 0;
        repeat (3) @(negedge clk);
        while (busy && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("wait_idle", busy, 0);
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] v;
        int busy_cycles;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rd_char",  rd_char,       8'h20);
        checkOutput("reset_wr_ready", wr_ready,      1);
        checkOutput("reset_cursor",   cursor,        0);
        checkOutput("reset_busy",     busy,          0);
        checkOutput("reset_offset",   scroll_offset, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < TL; i++) begin
            read_cell(i, v);
            checkOutput("default_cell", v, default_text[i]);
        end

        // A queued character stays invisible until vblank.
        applyStimulus(8'h41);
        read_cell(0, v);
        checkOutput("pre_vblank_cell0", v, 8'h44);
        rd_index = 4'd0;
        vblank   = 1'b1;
        repeat (3) @(posedge clk);
        #1 checkOutput("commit_a_cell0", rd_char, 8'h41);
        @(negedge clk);
        checkOutput("commit_a_cursor", cursor, 1);
        vblank = 1'b0;

        // Form feed clears all cells even though vblank drops part way through.
        vblank = 1'b1;
        applyStimulus(8'h0C);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 6) vblank = 1'b0;
            if (busy) busy_cycles++;
        end
        checkOutput("clear_busy_cycles", busy_cycles, 17);
        for (int i = 0; i < TL; i++) begin
            read_cell(i, v);
            checkOutput("clear_cell", v, 8'h20);
        end
        checkOutput("clear_cursor", cursor, 0);

        // Fill the queue outside vblank, then let vblank drain it.
        applyStimulus(8'h48);
        applyStimulus(8'h65);
        applyStimulus(8'h6C);
        applyStimulus(8'h6C);
        checkOutput("full_wr_ready", wr_ready, 0);
        vblank = 1'b1;
        applyStimulus(8'h6F);
        wait_idle();
        vblank = 1'b0;
        read_cell(0, v); checkOutput("hello_0", v, 8'h48);
        read_cell(1, v); checkOutput("hello_1", v, 8'h65);
        read_cell(2, v); checkOutput("hello_2", v, 8'h6C);
        read_cell(3, v); checkOutput("hello_3", v, 8'h6C);
        read_cell(4, v); checkOutput("hello_4", v, 8'h6F);
        checkOutput("hello_cursor", cursor, 5);

        // Seventeen printable characters wrap the cursor back over cell 0.
        vblank = 1'b1;
        applyStimulus(8'h0D);
        for (int i = 0; i < 17; i++) applyStimulus(8'(8'h61 + i));
        wait_idle();
        vblank = 1'b0;
        read_cell(0, v);  checkOutput("wrap_cell0",  v, 8'h71);
        read_cell(1, v);  checkOutput("wrap_cell1",  v, 8'h62);
        read_cell(15, v); checkOutput("wrap_cell15", v, 8'h70);
        checkOutput("wrap_cursor", cursor, 1);
        vblank = 1'b1;
        applyStimulus(8'h0D);
        wait_idle();
        vblank = 1'b0;
        checkOutput("cr_cursor", cursor, 0);
        read_cell(0, v); checkOutput("cr_cell0", v, 8'h71);
        read_cell(5, v); checkOutput("cr_cell5", v, 8'h66);

        // Marquee scrolling on the default text.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scroll_en = 1'b1;
        pulse_frames(3);
        checkOutput("scroll_3", scroll_offset, 0);
        pulse_frames(1);
        checkOutput("scroll_4", scroll_offset, 1);
        read_cell(0, v);
        checkOutput("scroll_cell0", v, 8'h72);
        pulse_frames(2);
        scroll_en = 1'b0;
        pulse_frames(3);
        checkOutput("scroll_hold", scroll_offset, 1);
        scroll_en = 1'b1;
        pulse_frames(2);
        checkOutput("scroll_resume", scroll_offset, 2);
        pulse_frames(56);
        checkOutput("scroll_wrap", scroll_offset, 0);
        read_cell(0, v);
        checkOutput("scroll_wrap_cell0", v, 8'h44);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
